// File: rtl/otp_ctrl_chk_arb_pkg.sv
// Shared types for the periodic-check arbiter: lifecycle escalation encoding,
// sparse FSM state encoding and its width.
package otp_ctrl_chk_arb_pkg;

  localparam int unsigned NumPartDefault = 10;

  // Multi-bit lifecycle signal; only the exact Off pattern counts as "off".
  localparam int unsigned LcTxWidth = 4;
  typedef logic [LcTxWidth-1:0] lc_tx_t;
  localparam lc_tx_t LcTxOn  = 4'b0101;
  localparam lc_tx_t LcTxOff = 4'b1010;

  // 9-bit sparse encoding, pairwise Hamming distance >= 5.
  localparam int unsigned ChkArbStateWidth = 9;
  typedef enum logic [ChkArbStateWidth-1:0] {
    IdleSt  = 9'b000011111,
    IssueSt = 9'b011100011,
    AckSt   = 9'b101101100,
    ErrorSt = 9'b110010000
  } chk_arb_state_e;

  // Loose test: anything that is not exactly Off is treated as asserted.
  function automatic logic lc_tx_test_not_off(lc_tx_t val);
    return val != LcTxOff;
  endfunction

endpackage

// File: rtl/otp_ctrl_rr_pick.sv
// Combinational round-robin picker: first set request bit at or above ptr,
// searching upward and wrapping from NumPart-1 back to 0.
module otp_ctrl_rr_pick #(
  parameter  int unsigned NumPart = 10,
  localparam int unsigned PtrW    = $clog2(NumPart)
) (
  input  logic [NumPart-1:0] req,
  input  logic [PtrW-1:0]    ptr,
  output logic               valid_c,
  output logic [PtrW-1:0]    idx_c
);

  localparam int unsigned SumW = PtrW + 1;

  logic [2*NumPart-1:0] dbl;
  logic [NumPart-1:0]   rot;
  logic [PtrW-1:0]      ofs;
  logic [SumW-1:0]      sum;

  // Rotate so ptr lands on bit 0, find the lowest set bit, rotate back.
  always_comb begin
    dbl = {req, req};
    rot = NumPart'(dbl >> ptr);
    ofs = '0;
    for (int i = NumPart - 1; i >= 0; i--) begin
      if (rot[i]) begin
        ofs = PtrW'(i);
      end
    end
    sum = SumW'(ptr) + SumW'(ofs);
    if (sum >= SumW'(NumPart)) begin
      sum = sum - SumW'(NumPart);
    end
    valid_c = |req;
    idx_c   = sum[PtrW-1:0];
  end

endmodule

// File: rtl/otp_ctrl_chk_arb.sv
// Serialises the timer's per-partition integrity/consistency check requests so
// only one partition at a time re-reads OTP; acks go back to the timer.
module otp_ctrl_chk_arb
  import otp_ctrl_chk_arb_pkg::*;
#(
  parameter  int unsigned NumPart = NumPartDefault,
  localparam int unsigned PtrW    = $clog2(NumPart)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NumPart-1:0] integ_chk_req_i,
  input  logic [NumPart-1:0] cnsty_chk_req_i,
  output logic [NumPart-1:0] integ_chk_ack_o,
  output logic [NumPart-1:0] cnsty_chk_ack_o,
  output logic [NumPart-1:0] part_chk_req_o,
  output logic               part_chk_cnsty_o,
  input  logic [NumPart-1:0] part_chk_done_i,
  input  logic               otp_prog_busy_i,
  input  lc_tx_t             escalate_en_i,
  output logic               busy_o,
  output logic               fsm_err_o
);

  chk_arb_state_e  state_q, state_d;
  logic [PtrW-1:0] rr_q, rr_d;
  logic [PtrW-1:0] sel_q, sel_d;
  logic            type_q, type_d;

  logic            integ_vld, cnsty_vld;
  logic [PtrW-1:0] integ_idx, cnsty_idx;

  logic [NumPart-1:0] sel_oh;
  logic [NumPart-1:0] req_d, integ_ack_d, cnsty_ack_d;
  logic               cnsty_d, busy_d, err_d;

  otp_ctrl_rr_pick #(
    .NumPart (NumPart)
  ) u_integ_pick (
    .req     (integ_chk_req_i),
    .ptr     (rr_q),
    .valid_c (integ_vld),
    .idx_c   (integ_idx)
  );

  otp_ctrl_rr_pick #(
    .NumPart (NumPart)
  ) u_cnsty_pick (
    .req     (cnsty_chk_req_i),
    .ptr     (rr_q),
    .valid_c (cnsty_vld),
    .idx_c   (cnsty_idx)
  );

  // State and selection register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IdleSt;
      rr_q    <= '0;
      sel_q   <= '0;
      type_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      sel_q   <= sel_d;
      type_q  <= type_d;
    end
  end

  // Next state; integrity wins over consistency, consistency waits out programming.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    sel_d   = sel_q;
    type_d  = type_q;
    case (state_q)
      IdleSt: begin
        if (integ_vld) begin
          sel_d   = integ_idx;
          type_d  = 1'b0;
          state_d = IssueSt;
        end else if (cnsty_vld && !otp_prog_busy_i) begin
          sel_d   = cnsty_idx;
          type_d  = 1'b1;
          state_d = IssueSt;
        end
      end
      IssueSt: begin
        if (part_chk_done_i[sel_q]) begin
          state_d = AckSt;
        end
      end
      AckSt: begin
        rr_d    = (sel_q == PtrW'(NumPart - 1)) ? '0 : sel_q + PtrW'(1);
        state_d = IdleSt;
      end
      ErrorSt: begin
        state_d = ErrorSt;
      end
      default: begin
        state_d = ErrorSt;
      end
    endcase
    if (lc_tx_test_not_off(escalate_en_i)) begin
      state_d = ErrorSt;
    end
  end

  // Output values for the upcoming state; registered alongside the state.
  always_comb begin
    req_d       = '0;
    integ_ack_d = '0;
    cnsty_ack_d = '0;
    cnsty_d     = 1'b0;
    busy_d      = 1'b0;
    err_d       = 1'b0;
    sel_oh      = NumPart'(1) << sel_d;
    case (state_d)
      IssueSt: begin
        req_d   = sel_oh;
        cnsty_d = type_d;
        busy_d  = 1'b1;
      end
      AckSt: begin
        if (type_d) begin
          cnsty_ack_d = sel_oh;
        end else begin
          integ_ack_d = sel_oh;
        end
        busy_d = 1'b1;
      end
      ErrorSt: begin
        err_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      part_chk_req_o   <= '0;
      part_chk_cnsty_o <= 1'b0;
      integ_chk_ack_o  <= '0;
      cnsty_chk_ack_o  <= '0;
      busy_o           <= 1'b0;
      fsm_err_o        <= 1'b0;
    end else begin
      part_chk_req_o   <= req_d;
      part_chk_cnsty_o <= cnsty_d;
      integ_chk_ack_o  <= integ_ack_d;
      cnsty_chk_ack_o  <= cnsty_ack_d;
      busy_o           <= busy_d;
      fsm_err_o        <= err_d;
    end
  end

endmodule

// File: tb/tb_otp_ctrl_chk_arb.sv
// Bench for otp_ctrl_chk_arb: vector table, directed service sequences and a
// randomized run against a transaction-level round-robin model.
module tb_otp_ctrl_chk_arb;
  import otp_ctrl_chk_arb_pkg::*;

  localparam int unsigned N = 10;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] integ, cnsty, done;
  logic         busy;
  lc_tx_t       esc;
  logic [N-1:0] integ_chk_ack, cnsty_chk_ack, part_chk_req;
  logic         part_chk_cnsty, busy_out, fsm_err;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [N-1:0] req;
    logic         cn;
    logic [N-1:0] ia;
    logic [N-1:0] ca;
    logic         bsy;
    logic         err;
  } obs_t;

  typedef struct {
    logic         rst;
    logic [N-1:0] ig;
    logic [N-1:0] cs;
    logic [N-1:0] dn;
    logic         pb;
    lc_tx_t       esc;
    obs_t         exp;
  } vec_t;

  vec_t tbl[$];

  otp_ctrl_chk_arb #(.NumPart(N)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .integ_chk_req_i  (integ),
    .cnsty_chk_req_i  (cnsty),
    .integ_chk_ack_o  (integ_chk_ack),
    .cnsty_chk_ack_o  (cnsty_chk_ack),
    .part_chk_req_o   (part_chk_req),
    .part_chk_cnsty_o (part_chk_cnsty),
    .part_chk_done_i  (done),
    .otp_prog_busy_i  (busy),
    .escalate_en_i    (esc),
    .busy_o           (busy_out),
    .fsm_err_o        (fsm_err)
  );

  always #5 clk = ~clk;

  function automatic logic [N-1:0] oh(int p);
    logic [N-1:0] one = N'(1);
    return one << p;
  endfunction

  function automatic obs_t o(logic [N-1:0] req, logic cn, logic [N-1:0] ia,
                             logic [N-1:0] ca, logic b, logic e);
    obs_t r;
    r.req = req; r.cn = cn; r.ia = ia; r.ca = ca; r.bsy = b; r.err = e;
    return r;
  endfunction

  function automatic vec_t mk(logic r, logic [N-1:0] ig, logic [N-1:0] cs,
                              logic [N-1:0] dn, logic pb, lc_tx_t ev, obs_t ex);
    vec_t v;
    v.rst = r; v.ig = ig; v.cs = cs; v.dn = dn; v.pb = pb; v.esc = ev; v.exp = ex;
    return v;
  endfunction

  // Index of the first set bit at or above start, wrapping; -1 if none.
  function automatic int rr_search(logic [N-1:0] v, int start);
    for (int k = 0; k < N; k++) begin
      if (v[(start + k) % N]) return (start + k) % N;
    end
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string name, obs_t exp);
    obs_t act;
    act.req = part_chk_req;
    act.cn  = part_chk_cnsty & (|part_chk_req);
    act.ia  = integ_chk_ack;
    act.ca  = cnsty_chk_ack;
    act.bsy = busy_out;
    act.err = fsm_err;
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got req=%h cn=%b iack=%h cack=%h busy=%b err=%b, want req=%h cn=%b iack=%h cack=%h busy=%b err=%b",
               name, $time, act.req, act.cn, act.ia, act.ca, act.bsy, act.err,
               exp.req, exp.cn, exp.ia, exp.ca, exp.bsy, exp.err);
    end
  endtask

  // Idle arbiter with request for p pending: issue, hold, done, ack, gap.
  task automatic service(int p, logic t, int hold);
    tick();
    check("issue", o(oh(p), t, '0, '0, 1'b1, 1'b0));
    repeat (hold) begin
      tick();
      check("hold", o(oh(p), t, '0, '0, 1'b1, 1'b0));
    end
    done = oh(p);
    tick();
    check("ack", o('0, 1'b0, t ? '0 : oh(p), t ? oh(p) : '0, 1'b1, 1'b0));
    done = '0;
    if (t) cnsty[p] = 1'b0;
    else   integ[p] = 1'b0;
    tick();
    check("gap", o('0, 1'b0, '0, '0, 1'b0, 1'b0));
  endtask

  int     m_ph, m_sel, m_rr, p;
  logic   m_t;
  obs_t   e;

  initial begin
    rst = 1'b1; integ = '0; cnsty = '0; done = '0; busy = 1'b0; esc = LcTxOff;

    tbl.push_back(mk(1, 10'h000, 10'h000, 10'h000, 0, LcTxOff, o(10'h000, 0, 10'h000, 10'h000, 0, 0)));
    tbl.push_back(mk(0, 10'h004, 10'h010, 10'h000, 0, LcTxOff, o(10'h004, 0, 10'h000, 10'h000, 1, 0)));
    tbl.push_back(mk(0, 10'h004, 10'h010, 10'h000, 0, LcTxOff, o(10'h004, 0, 10'h000, 10'h000, 1, 0)));
    tbl.push_back(mk(0, 10'h004, 10'h010, 10'h004, 0, LcTxOff, o(10'h000, 0, 10'h004, 10'h000, 1, 0)));
    tbl.push_back(mk(0, 10'h000, 10'h010, 10'h000, 0, LcTxOff, o(10'h000, 0, 10'h000, 10'h000, 0, 0)));
    tbl.push_back(mk(0, 10'h000, 10'h010, 10'h000, 0, LcTxOff, o(10'h010, 1, 10'h000, 10'h000, 1, 0)));
    tbl.push_back(mk(0, 10'h000, 10'h010, 10'h010, 0, LcTxOff, o(10'h000, 0, 10'h000, 10'h010, 1, 0)));
    tbl.push_back(mk(0, 10'h000, 10'h000, 10'h000, 0, LcTxOff, o(10'h000, 0, 10'h000, 10'h000, 0, 0)));
    tbl.push_back(mk(0, 10'h000, 10'h008, 10'h000, 0, LcTxOff, o(10'h008, 1, 10'h000, 10'h000, 1, 0)));
    tbl.push_back(mk(0, 10'h000, 10'h008, 10'h020, 0, LcTxOff, o(10'h008, 1, 10'h000, 10'h000, 1, 0)));
    tbl.push_back(mk(0, 10'h000, 10'h008, 10'h008, 0, LcTxOff, o(10'h000, 0, 10'h000, 10'h008, 1, 0)));
    tbl.push_back(mk(0, 10'h000, 10'h000, 10'h000, 0, LcTxOff, o(10'h000, 0, 10'h000, 10'h000, 0, 0)));
    tbl.push_back(mk(0, 10'h002, 10'h000, 10'h000, 0, LcTxOff, o(10'h002, 0, 10'h000, 10'h000, 1, 0)));
    tbl.push_back(mk(0, 10'h002, 10'h000, 10'h000, 0, LcTxOn,  o(10'h000, 0, 10'h000, 10'h000, 0, 1)));
    tbl.push_back(mk(0, 10'h002, 10'h000, 10'h002, 0, LcTxOn,  o(10'h000, 0, 10'h000, 10'h000, 0, 1)));
    tbl.push_back(mk(0, 10'h002, 10'h000, 10'h002, 0, LcTxOff, o(10'h000, 0, 10'h000, 10'h000, 0, 1)));
    tbl.push_back(mk(1, 10'h002, 10'h000, 10'h000, 0, LcTxOff, o(10'h000, 0, 10'h000, 10'h000, 0, 0)));
    tbl.push_back(mk(0, 10'h000, 10'h000, 10'h000, 0, LcTxOff, o(10'h000, 0, 10'h000, 10'h000, 0, 0)));
    tbl.push_back(mk(0, 10'h001, 10'h000, 10'h000, 0, LcTxOff, o(10'h001, 0, 10'h000, 10'h000, 1, 0)));
    tbl.push_back(mk(1, 10'h001, 10'h000, 10'h001, 0, LcTxOff, o(10'h000, 0, 10'h000, 10'h000, 0, 0)));
    tbl.push_back(mk(0, 10'h000, 10'h000, 10'h000, 0, LcTxOff, o(10'h000, 0, 10'h000, 10'h000, 0, 0)));
    tbl.push_back(mk(0, 10'h004, 10'h000, 10'h000, 0, LcTxOff, o(10'h004, 0, 10'h000, 10'h000, 1, 0)));
    tbl.push_back(mk(0, 10'h004, 10'h000, 10'h000, 0, 4'h3,    o(10'h000, 0, 10'h000, 10'h000, 0, 1)));
    tbl.push_back(mk(1, 10'h000, 10'h000, 10'h000, 0, LcTxOff, o(10'h000, 0, 10'h000, 10'h000, 0, 0)));

    foreach (tbl[i]) begin
      rst = tbl[i].rst; integ = tbl[i].ig; cnsty = tbl[i].cs;
      done = tbl[i].dn; busy = tbl[i].pb; esc = tbl[i].esc;
      tick();
      check($sformatf("vec%0d", i), tbl[i].exp);
    end

    // All ten partitions in order, done two cycles after each request.
    rst = 1'b1; integ = '0; cnsty = '0; done = '0; busy = 1'b0; esc = LcTxOff;
    tick();
    check("reset", o('0, 1'b0, '0, '0, 1'b0, 1'b0));
    rst = 1'b0;
    integ = 10'h3FF;
    for (int k = 0; k < N; k++) service(k, 1'b0, 1);
    tick();
    check("rest", o('0, 1'b0, '0, '0, 1'b0, 1'b0));

    // Pointer moved to 7, then consistency bits 0,1,7 served 7,0,1.
    integ = 10'h040;
    service(6, 1'b0, 0);
    cnsty = 10'h083;
    service(7, 1'b1, 0);
    service(0, 1'b1, 2);
    service(1, 1'b1, 0);

    // Programming busy holds back consistency but not integrity.
    cnsty = 10'h001; busy = 1'b1;
    repeat (20) begin
      tick();
      check("prog_busy", o('0, 1'b0, '0, '0, 1'b0, 1'b0));
    end
    busy = 1'b0;
    service(0, 1'b1, 0);
    busy = 1'b1; cnsty = 10'h002; integ = 10'h100;
    service(8, 1'b0, 0);
    repeat (5) begin
      tick();
      check("prog_busy2", o('0, 1'b0, '0, '0, 1'b0, 1'b0));
    end
    busy = 1'b0;
    service(1, 1'b1, 0);

    // Randomized traffic against the round-robin model.
    rst = 1'b1; integ = '0; cnsty = '0; done = '0; busy = 1'b0;
    tick();
    rst = 1'b0;
    m_ph = 0; m_rr = 0; m_sel = 0; m_t = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      e = '0;
      case (m_ph)
        0: begin
          p = -1;
          if (integ != '0) begin
            p = rr_search(integ, m_rr); m_t = 1'b0;
          end else if (cnsty != '0 && !busy) begin
            p = rr_search(cnsty, m_rr); m_t = 1'b1;
          end
          if (p >= 0) begin
            m_sel = p; m_ph = 1;
            e.req = oh(p); e.cn = m_t; e.bsy = 1'b1;
          end
        end
        1: begin
          e.bsy = 1'b1;
          if (done[m_sel]) begin
            m_ph = 2;
            if (m_t) e.ca = oh(m_sel);
            else     e.ia = oh(m_sel);
          end else begin
            e.req = oh(m_sel); e.cn = m_t;
          end
        end
        default: begin
          m_ph = 0;
          m_rr = (m_sel + 1) % N;
        end
      endcase
      tick();
      check("rand", e);

      if (m_ph == 2) begin
        if (m_t) cnsty[m_sel] = 1'b0;
        else     integ[m_sel] = 1'b0;
      end
      if ($urandom_range(0, 5) == 0) integ[$urandom_range(0, N - 1)] = 1'b1;
      if ($urandom_range(0, 3) == 0) cnsty[$urandom_range(0, N - 1)] = 1'b1;
      if (m_ph == 1 && $urandom_range(0, 40) == 0) begin
        if (m_t) cnsty[m_sel] = 1'b0;
        else     integ[m_sel] = 1'b0;
      end
      if ($urandom_range(0, 15) == 0) busy = ~busy;
      done = '0;
      if (part_chk_req != '0 && $urandom_range(0, 2) == 0) done = part_chk_req;
      done = done | (N'($urandom) & N'($urandom) & N'($urandom) & ~part_chk_req);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
